sgbm_frame_ctrl: RTL and testbench
==================================

Name: sgbm_frame_ctrl

Overview:
- Frame sequencer for the SGBM pipeline.
- On a start pulse it raster-scans one left/right frame pair out of dual frame-buffer RAMs (1-cycle read latency). It feeds the pixels to the sgbm top as en/grey_left/grey_right/row/col.
- It then counts aggr_valid results until the full frame has emerged and reports done, or error on a stalled pipeline.
- Sits between the frame-buffer write side and the sgbm instance.

Parameters:
- IMAGE_ROW, 200, rows per frame
- IMAGE_COL, 400, columns per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMAGE_ROW*IMAGE_COL
- DRAIN_TIMEOUT, 4096, max idle cycles without aggr_valid in DRAIN before abort

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle frame start request
- pause  in  1  level; holds pixel issue while high
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame end (normal or abort)
- error  out  1  sticky; set on drain timeout
- rd_en  out  1  frame-buffer read enable (both buffers)
- rd_addr  out  ADDR_W  frame-buffer read address, row*IMAGE_COL+col
- left_data  in  8  left buffer read data, valid 1 cycle after rd_en
- right_data  in  8  right buffer read data, valid 1 cycle after rd_en
- pix_en  out  1  to sgbm en
- pix_left  out  8  to sgbm grey_left
- pix_right  out  8  to sgbm grey_right
- pix_row  out  10  to sgbm grey_row_left and grey_row_right
- pix_col  out  10  to sgbm grey_col_left and grey_col_right
- aggr_valid  in  1  from sgbm aggr_valid
- out_count  out  ADDR_W  aggr_valid results counted this frame

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - busy, done, error, rd_en, pix_en are 0.
  - rd_addr, pix_left, pix_right, pix_row, pix_col, out_count are 0.
  - All internal counters are 0.
- FSM states: IDLE, FETCH, DRAIN, FINISH.
- IDLE:
  - start=1 moves to FETCH next cycle.
  - On entry to FETCH: row/col/addr counters := 0, out_count := 0, error := 0, busy := 1.
  - aggr_valid is ignored in IDLE.
- FETCH:
  - Each cycle with pause=0: rd_en=1, rd_addr=current addr.
  - The same cycle advances col, then wraps col to 0 and advances row at IMAGE_COL-1; addr += 1.
  - With pause=1: rd_en=0 and counters hold.
  - The cycle that issues (IMAGE_ROW-1, IMAGE_COL-1) moves to DRAIN.
  - start is ignored while busy.
- Pixel output (1-cycle latency after issue):
  - pix_en = rd_en delayed 1 cycle.
  - pix_left/pix_right = left_data/right_data sampled in that cycle.
  - pix_row/pix_col = issued row/col delayed 1 cycle.
  - pix_* data holds its last value when pix_en=0.
  - Issue at cycle t gives pix_en at t+1. The final pix_en pulse occurs in the first DRAIN cycle.
- Result counting:
  - In FETCH and DRAIN, every aggr_valid=1 increments out_count, saturating at IMAGE_ROW*IMAGE_COL.
- DRAIN:
  - Idle counter resets to 0 on every aggr_valid and otherwise increments.
  - If out_count (including the current aggr_valid) reaches IMAGE_ROW*IMAGE_COL, go to FINISH.
  - Else if the idle counter reaches DRAIN_TIMEOUT-1 with no aggr_valid, set error=1 and go to FINISH.
  - Simultaneous last aggr_valid and timeout: completion wins, error stays 0.
- FINISH:
  - done=1 for exactly this cycle; busy=0 from the next cycle.
  - Returns to IDLE.
  - start asserted in FINISH is ignored.
  - error stays set until the next accepted start.
- Reset mid-frame:
  - Aborts immediately to reset values. No done pulse.
  - pix_en=0 the cycle after rst is sampled.
- Widths: pix_row/pix_col are zero-extended from internal counters. IMAGE_ROW and IMAGE_COL must each be <= 1024.

Test Plan:
- IMAGE_ROW=4, IMAGE_COL=5, RAM preloaded left[a]=a, right[a]=a+100, sgbm model returning aggr_valid 10 cycles after each pix_en; start -> rd_addr 0..19 on 20 consecutive cycles; pix_en 20 cycles with pix_left=addr, pix_right=addr+100, (row,col) raster (0,0)..(3,4); done pulse once out_count=20; error=0.
- Same config, pause high for 3 cycles after the 7th issue -> rd_en low 3 cycles, rd_addr resumes at 7; no duplicate or skipped (row,col) at pix_*; done still after 20 results.
- Model drops the last 2 aggr_valid, DRAIN_TIMEOUT=16 -> error=1 and done pulse 16 cycles after the 18th result; out_count=18; next start clears error.
- start re-pulsed during FETCH and during FINISH -> ignored: rd_addr sequence uninterrupted, exactly one done, busy returns to 0.
- rst asserted at issue 9 -> next cycle rd_en=0, pix_en=0, busy=0, out_count=0, no done; a fresh start scans again from addr 0.
- Default params (200x400) -> rd_addr final value 79999, out_count=80000 at done, pix_row max 199, pix_col max 399.

Source files
------------

// File: rtl/sgbm_frame_ctrl.sv
// Frame sequencer for the SGBM pipeline: raster-scans one left/right frame pair out of
// the frame buffers into the sgbm core, then counts aggregation results until the frame completes.
module sgbm_frame_ctrl #(
    parameter int IMAGE_ROW     = 200,
    parameter int IMAGE_COL     = 400,
    parameter int ADDR_W        = 17,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        left_data,
    input  logic [7:0]        right_data,
    output logic              pix_en,
    output logic [7:0]        pix_left,
    output logic [7:0]        pix_right,
    output logic [9:0]        pix_row,
    output logic [9:0]        pix_col,
    input  logic              aggr_valid,
    output logic [ADDR_W-1:0] out_count,
    output logic [1:0]        state_dbg
);

    localparam int                IDLE_W    = $clog2(DRAIN_TIMEOUT) + 1;
    localparam int                TOTAL_INT = IMAGE_ROW * IMAGE_COL;
    localparam logic [ADDR_W-1:0] TOTAL     = ADDR_W'(TOTAL_INT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);
    localparam logic [9:0]        ROW_LAST  = 10'(IMAGE_ROW - 1);
    localparam logic [9:0]        COL_LAST  = 10'(IMAGE_COL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state;
    logic [9:0]        row_q;
    logic [9:0]        col_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IDLE_W-1:0] idle_q;
    logic [9:0]        prow_q;
    logic [9:0]        pcol_q;
    logic [7:0]        hold_left;
    logic [7:0]        hold_right;

    logic              issue;
    logic              last_issue;
    logic              count_inc;
    logic [ADDR_W-1:0] count_next;
    logic [IDLE_W-1:0] idle_next;

    always_comb begin
        issue      = 1'b0;
        last_issue = 1'b0;
        count_inc  = 1'b0;
        if (state == FETCH && !pause) begin
            issue      = 1'b1;
            last_issue = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
        if ((state == FETCH || state == DRAIN) && aggr_valid && out_count != TOTAL) begin
            count_inc = 1'b1;
        end
        count_next = out_count + ADDR_W'(count_inc);
        idle_next  = idle_q + IDLE_W'(1);
    end

    // Pixel stream: one beat per cycle with pix_en high, no backpressure. Read data arrives
    // one cycle after rd_en, the same cycle pix_en rises, so it is passed straight through
    // and captured only to hold the value while pix_en is low.
    assign rd_en     = issue;
    assign rd_addr   = addr_q;
    assign pix_left  = pix_en ? left_data : hold_left;
    assign pix_right = pix_en ? right_data : hold_right;
    assign pix_row   = prow_q;
    assign pix_col   = pcol_q;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            pix_en     <= 1'b0;
            out_count  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            idle_q     <= '0;
            prow_q     <= '0;
            pcol_q     <= '0;
            hold_left  <= '0;
            hold_right <= '0;
        end else begin
            pix_en    <= issue;
            done      <= 1'b0;
            out_count <= count_next;
            if (issue) begin
                prow_q <= row_q;
                pcol_q <= col_q;
            end
            if (pix_en) begin
                hold_left  <= left_data;
                hold_right <= right_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        row_q     <= '0;
                        col_q     <= '0;
                        addr_q    <= '0;
                        idle_q    <= '0;
                        out_count <= '0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    // The final issue leaves the counters on the last pixel address.
                    if (last_issue) begin
                        state  <= DRAIN;
                        idle_q <= '0;
                    end else if (issue) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 10'd1;
                        end else begin
                            col_q <= col_q + 10'd1;
                        end
                    end
                end
                DRAIN: begin
                    idle_q <= aggr_valid ? '0 : idle_next;
                    if (count_next == TOTAL) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else if (!aggr_valid && idle_next == IDLE_LAST) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sgbm_frame_ctrl.sv
// Bench for sgbm_frame_ctrl: a 4x5 frame with RAM and sgbm latency models checked by a
// scoreboard, plus a full-size 200x400 frame scanned in parallel.
module tb_sgbm_frame_ctrl;

    localparam int R   = 4;
    localparam int C   = 5;
    localparam int N   = R * C;
    localparam int TO  = 16;
    localparam int LAT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- small DUT (4x5) ----------------
    logic        rst = 1'b1, start = 1'b0, pause = 1'b0;
    logic        busy, done, error, rd_en, pix_en, aggr_valid;
    logic [16:0] rd_addr, out_count;
    logic [7:0]  left_data = '0, right_data = '0, pix_left, pix_right;
    logic [9:0]  pix_row, pix_col;
    logic [1:0]  state_dbg;

    sgbm_frame_ctrl #(.IMAGE_ROW(R), .IMAGE_COL(C), .ADDR_W(17), .DRAIN_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .busy(busy), .done(done),
        .error(error), .rd_en(rd_en), .rd_addr(rd_addr), .left_data(left_data),
        .right_data(right_data), .pix_en(pix_en), .pix_left(pix_left), .pix_right(pix_right),
        .pix_row(pix_row), .pix_col(pix_col), .aggr_valid(aggr_valid), .out_count(out_count),
        .state_dbg(state_dbg)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            left_data  <= rd_addr[7:0];
            right_data <= rd_addr[7:0] + 8'd100;
        end
    end

    logic [LAT-1:0] dly = '0;
    int pix_total = 0, pix_base = 0;
    bit drop_mode = 1'b0;
    always @(posedge clk) begin
        dly <= {dly[LAT-2:0], pix_en && !(drop_mode && (pix_total - pix_base) >= N - 2)};
        if (pix_en) pix_total <= pix_total + 1;
    end
    assign aggr_valid = dly[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [16:0] addr_q[$];
    logic [35:0] exp_q[$];
    int issue_cnt = 0, aggr_cnt = 0, done_cnt = 0;
    int last_rd_cyc = 0, last_aggr_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                issue_cnt++;
                last_rd_cyc = cyc;
                if (addr_q.size() == 0) check("rd_extra", 1, 0);
                else check("rd_addr", rd_addr, addr_q.pop_front());
            end
            if (pix_en) begin
                if (exp_q.size() == 0) check("pix_extra", 1, 0);
                else check("pix", {pix_row, pix_col, pix_left, pix_right}, exp_q.pop_front());
            end
            if (aggr_valid) begin
                aggr_cnt++;
                last_aggr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic load_frame();
        logic [9:0] r, c;
        logic [7:0] l, rr;
        addr_q.delete();
        exp_q.delete();
        for (int a = 0; a < N; a++) begin
            r  = 10'(a / C);
            c  = 10'(a % C);
            l  = 8'(a);
            rr = 8'(a + 100);
            addr_q.push_back(17'(a));
            exp_q.push_back({r, c, l, rr});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1);
    endtask

    task automatic wait_issues(input int base, input int n);
        bit hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (issue_cnt - base == n) begin
                hit = 1'b1;
                break;
            end
        end
        check("issue_wait", hit, 1);
    endtask

    // ---------------- big DUT (default 200x400) ----------------
    logic        b_rst = 1'b1, b_start = 1'b0;
    logic        b_busy, b_done, b_error, b_rd_en, b_pix_en, b_aggr_valid;
    logic [16:0] b_rd_addr, b_out_count;
    logic [7:0]  b_left_data = '0, b_right_data = '0, b_pix_left, b_pix_right;
    logic [9:0]  b_pix_row, b_pix_col;
    logic [1:0]  b_state_dbg;
    logic [LAT-1:0] b_dly = '0;

    sgbm_frame_ctrl big (
        .clk(clk), .rst(b_rst), .start(b_start), .pause(1'b0), .busy(b_busy), .done(b_done),
        .error(b_error), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .left_data(b_left_data),
        .right_data(b_right_data), .pix_en(b_pix_en), .pix_left(b_pix_left),
        .pix_right(b_pix_right), .pix_row(b_pix_row), .pix_col(b_pix_col),
        .aggr_valid(b_aggr_valid), .out_count(b_out_count), .state_dbg(b_state_dbg)
    );

    always @(posedge clk) begin
        if (b_rd_en) begin
            b_left_data  <= b_rd_addr[7:0];
            b_right_data <= b_rd_addr[7:0] + 8'd100;
        end
        b_dly <= {b_dly[LAT-2:0], b_pix_en};
    end
    assign b_aggr_valid = b_dly[LAT-1];

    int b_exp_addr = 0, b_addr_bad = 0, b_pix_bad = 0, b_max_row = 0, b_max_col = 0;
    int b_last_addr = -1, b_v = 0;
    logic [7:0] b_lo;
    always @(negedge clk) begin
        if (!b_rst && b_rd_en) begin
            if (int'(b_rd_addr) != b_exp_addr) b_addr_bad++;
            b_exp_addr++;
            b_last_addr = int'(b_rd_addr);
        end
        if (!b_rst && b_pix_en) begin
            b_v  = int'(b_pix_row) * 400 + int'(b_pix_col);
            b_lo = b_v[7:0];
            if (b_pix_left != b_lo || b_pix_right != b_lo + 8'd100) b_pix_bad++;
            if (int'(b_pix_row) > b_max_row) b_max_row = int'(b_pix_row);
            if (int'(b_pix_col) > b_max_col) b_max_col = int'(b_pix_col);
        end
    end

    bit big_fin = 1'b0;
    initial begin
        bit got;
        repeat (3) @(posedge clk);
        #1 b_rst = 1'b0;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 85000; k++) begin
            @(negedge clk);
            if (b_done) begin
                got = 1'b1;
                break;
            end
        end
        check("big_done", got, 1);
        check("big_out_count", b_out_count, 80000);
        check("big_error", b_error, 0);
        check("big_last_addr", b_last_addr, 79999);
        check("big_rd_addr_hold", b_rd_addr, 79999);
        check("big_max_row", b_max_row, 199);
        check("big_max_col", b_max_col, 399);
        check("big_addr_seq_bad", b_addr_bad, 0);
        check("big_pix_bad", b_pix_bad, 0);
        check("big_issues", b_exp_addr, 80000);
        big_fin = 1'b1;
    end

    // ---------------- small-DUT sequence ----------------
    initial begin
        bit got;
        int base, first_cyc, dbase, abase;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_pix_en", pix_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_pix", {pix_row, pix_col, pix_left, pix_right}, 0);
        check("rst_out_count", out_count, 0);
        check("rst_state", state_dbg, 0);
        @(posedge clk); #1 rst = 1'b0;

        // plain frame
        load_frame();
        base = issue_cnt;
        pulse_start();
        @(negedge clk);
        check("t1_first_rd", rd_en, 1);
        check("t1_busy", busy, 1);
        check("t1_state_fetch", state_dbg, 1);
        first_cyc = cyc;
        wait_done("t1_done", 200, got);
        check("t1_out_count", out_count, N);
        check("t1_error", error, 0);
        check("t1_issues", issue_cnt - base, N);
        check("t1_contiguous", last_rd_cyc - first_cyc, N - 1);
        check("t1_queues", addr_q.size() + exp_q.size(), 0);
        @(negedge clk);
        check("t1_busy_after", busy, 0);
        check("t1_done_pulse", done, 0);

        // pause for 3 cycles after the 7th issue
        load_frame();
        base = issue_cnt;
        pulse_start();
        wait_issues(base, 7);
        #1 pause = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t2_paused_rd", rd_en, 0);
        end
        @(posedge clk); #1 pause = 1'b0;
        @(negedge clk);
        check("t2_resume_addr", rd_addr, 7);
        wait_done("t2_done", 200, got);
        check("t2_out_count", out_count, N);
        check("t2_queues", addr_q.size() + exp_q.size(), 0);

        // last two results dropped -> drain timeout
        repeat (5) @(posedge clk);
        load_frame();
        drop_mode = 1'b1;
        pix_base = pix_total;
        abase = aggr_cnt;
        pulse_start();
        wait_done("t3_done", 300, got);
        check("t3_error", error, 1);
        check("t3_out_count", out_count, N - 2);
        @(negedge clk);
        check("t3_aggr_seen", aggr_cnt - abase, N - 2);
        check("t3_timeout_gap", done_cyc - last_aggr_cyc, TO);
        check("t3_error_sticky", error, 1);
        drop_mode = 1'b0;
        load_frame();
        pulse_start();
        @(negedge clk);
        check("t3_error_cleared", error, 0);
        check("t3_count_cleared", out_count, 0);
        wait_done("t3b_done", 200, got);
        check("t3b_error", error, 0);

        // start re-pulsed during FETCH and during FINISH
        repeat (3) @(posedge clk);
        load_frame();
        base = issue_cnt;
        dbase = done_cnt;
        pulse_start();
        wait_issues(base, 5);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                start = 1'b1;
                break;
            end
        end
        check("t4_done_seen", got, 1);
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t4_one_done", done_cnt - dbase, 1);
        check("t4_busy", busy, 0);
        check("t4_issues", issue_cnt - base, N);
        check("t4_queues", addr_q.size() + exp_q.size(), 0);

        // reset in the middle of a scan
        load_frame();
        base = issue_cnt;
        pulse_start();
        wait_issues(base, 9);
        #1 rst = 1'b1;
        dbase = done_cnt;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_rd_en", rd_en, 0);
        check("t5_pix_en", pix_en, 0);
        check("t5_busy", busy, 0);
        check("t5_out_count", out_count, 0);
        addr_q.delete();
        exp_q.delete();
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t5_no_done", done_cnt - dbase, 0);
        load_frame();
        pulse_start();
        wait_done("t5b_done", 200, got);
        check("t5b_out_count", out_count, N);
        check("t5b_queues", addr_q.size() + exp_q.size(), 0);

        got = big_fin;
        for (int k = 0; k < 90000 && !got; k++) begin
            @(posedge clk);
            got = big_fin;
        end
        check("big_finished", got, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
